// File: rtl/snake_body_engine.sv
// Snake body store and move engine: circular segment buffer, wall/self collision check,
// and tail-erase / head-draw pixel streaming towards a VGA plot port.
module snake_body_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int CELL     = 4,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 20,
    parameter int INIT_Y   = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         step,
    input  logic [1:0]                   dir,
    input  logic [$clog2(GRID_W)-1:0]    food_cx,
    input  logic [$clog2(GRID_H)-1:0]    food_cy,
    output logic                         busy,
    output logic                         done,
    output logic                         dead,
    output logic                         ate,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         plot_en,
    output logic [X_W-1:0]               plot_x,
    output logic [Y_W-1:0]               plot_y,
    output logic                         plot_colour
);

    localparam int CX_W  = $clog2(GRID_W);
    localparam int CY_W  = $clog2(GRID_H);
    localparam int CW    = CX_W + CY_W;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW    = (CELL > 1) ? $clog2(CELL * CELL) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT_WR   = 4'd1;
    localparam logic [3:0] S_INIT_DRAW = 4'd2;
    localparam logic [3:0] S_MOVE      = 4'd3;
    localparam logic [3:0] S_CHECK     = 4'd4;
    localparam logic [3:0] S_ERASE     = 4'd5;
    localparam logic [3:0] S_PUSH      = 4'd6;
    localparam logic [3:0] S_DRAW      = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    logic [3:0]       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [PW-1:0]    pix;
    logic [PTR_W-1:0] head_ptr;
    logic [CX_W-1:0]  head_x, nh_x;
    logic [CY_W-1:0]  head_y, nh_y;
    logic [CW-1:0]    tail_cell;
    logic [1:0]       cur_dir;
    logic             grow, grow_eff;

    logic [CW-1:0]    mem [MAX_LEN];
    logic [CW-1:0]    rd_data;
    logic [PTR_W-1:0] rd_addr, wr_addr;
    logic [CW-1:0]    wr_data;
    logic             wr_en;

    function automatic logic [PTR_W-1:0] ptr_sub(input int a, input int b);
        int r;
        r = a - b;
        if (r < 0) r = r + MAX_LEN;
        return PTR_W'(r);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] a);
        return (int'(a) == MAX_LEN - 1) ? '0 : a + 1'b1;
    endfunction

    // Move decode: reversal keeps the current heading; walls detected before wrap.
    logic [1:0]      eff_dir;
    logic [CX_W-1:0] nx;
    logic [CY_W-1:0] ny;
    logic            wall, grow_c, pix_last, match;

    always_comb begin
        eff_dir = dir;
        if (dir[1] == cur_dir[1] && dir[0] != cur_dir[0]) eff_dir = cur_dir;
        nx   = head_x;
        ny   = head_y;
        wall = 1'b0;
        case (eff_dir)
            2'b00: begin wall = (int'(head_x) == GRID_W - 1); nx = head_x + 1'b1; end
            2'b01: begin wall = (head_x == '0);               nx = head_x - 1'b1; end
            2'b10: begin wall = (int'(head_y) == GRID_H - 1); ny = head_y + 1'b1; end
            default: begin wall = (head_y == '0);             ny = head_y - 1'b1; end
        endcase
        grow_c   = (nx == food_cx) && (ny == food_cy);
        pix_last = (int'(pix) == CELL * CELL - 1);
        // cnt-1 is the segment whose read data is present; the tail is skipped when it vacates.
        match    = (cnt != '0) && (rd_data == {nh_x, nh_y}) && !((cnt == len) && !grow_eff);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = head_ptr;
        wr_data = {nh_x, nh_y};
        if (state == S_INIT_WR) begin
            wr_en   = 1'b1;
            wr_addr = PTR_W'(cnt);
            wr_data = {CX_W'(INIT_X), CY_W'(INIT_Y + INIT_LEN - 1 - int'(cnt))};
        end else if (state == S_PUSH) begin
            wr_en   = 1'b1;
            wr_addr = ptr_inc(head_ptr);
        end
        rd_addr = (cnt < len) ? ptr_sub(int'(head_ptr), int'(cnt)) : head_ptr;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    logic            plot_en_c, colour_c;
    logic [CX_W-1:0] cell_x;
    logic [CY_W-1:0] cell_y;
    logic [X_W-1:0]  px_c;
    logic [Y_W-1:0]  py_c;

    always_comb begin
        plot_en_c = 1'b0;
        colour_c  = 1'b0;
        cell_x    = nh_x;
        cell_y    = nh_y;
        case (state)
            S_INIT_DRAW: begin
                plot_en_c = 1'b1;
                colour_c  = 1'b1;
                cell_x    = CX_W'(INIT_X);
                cell_y    = CY_W'(INIT_Y + int'(cnt));
            end
            S_ERASE: begin
                plot_en_c = 1'b1;
                cell_x    = tail_cell[CW-1:CY_W];
                cell_y    = tail_cell[CY_W-1:0];
            end
            S_DRAW: begin
                plot_en_c = 1'b1;
                colour_c  = 1'b1;
            end
            default: ;
        endcase
        px_c = X_W'(int'(cell_x) * CELL + int'(pix) % CELL);
        py_c = Y_W'(int'(cell_y) * CELL + int'(pix) / CELL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            len         <= '0;
            cnt         <= '0;
            pix         <= '0;
            head_ptr    <= '0;
            head_x      <= '0;
            head_y      <= '0;
            nh_x        <= '0;
            nh_y        <= '0;
            tail_cell   <= '0;
            cur_dir     <= 2'b00;
            grow        <= 1'b0;
            grow_eff    <= 1'b0;
            dead        <= 1'b0;
            plot_en     <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= 1'b0;
        end else begin
            plot_en     <= plot_en_c;
            plot_x      <= px_c;
            plot_y      <= py_c;
            plot_colour <= colour_c;
            case (state)
                S_IDLE: if (step && !dead) state <= S_MOVE;
                S_INIT_WR: begin
                    len <= cnt + 1'b1;
                    if (int'(cnt) == INIT_LEN - 1) begin
                        head_ptr <= PTR_W'(INIT_LEN - 1);
                        head_x   <= CX_W'(INIT_X);
                        head_y   <= CY_W'(INIT_Y);
                        dead     <= 1'b0;
                        cur_dir  <= 2'b00;
                        cnt      <= '0;
                        state    <= S_INIT_DRAW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT_DRAW: begin
                    pix <= pix + 1'b1;
                    if (pix_last) begin
                        pix <= '0;
                        if (int'(cnt) == INIT_LEN - 1) state <= S_DONE;
                        else cnt <= cnt + 1'b1;
                    end
                end
                S_MOVE: begin
                    cur_dir <= eff_dir;
                    cnt     <= '0;
                    pix     <= '0;
                    if (wall) begin
                        dead  <= 1'b1;
                        grow  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        nh_x     <= nx;
                        nh_y     <= ny;
                        grow     <= grow_c;
                        grow_eff <= grow_c && (int'(len) != MAX_LEN);
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cnt == len) tail_cell <= rd_data;
                    if (match) begin
                        dead  <= 1'b1;
                        grow  <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt == len) begin
                        state <= grow_eff ? S_PUSH : S_ERASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ERASE: begin
                    pix <= pix + 1'b1;
                    if (pix_last) begin
                        pix   <= '0;
                        len   <= len - 1'b1;
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    head_ptr <= ptr_inc(head_ptr);
                    head_x   <= nh_x;
                    head_y   <= nh_y;
                    len      <= len + 1'b1;
                    state    <= S_DRAW;
                end
                S_DRAW: begin
                    pix <= pix + 1'b1;
                    if (pix_last) begin
                        pix   <= '0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // start overrides everything except an initialisation already in flight.
            if (start && state != S_INIT_WR && state != S_INIT_DRAW) begin
                state    <= S_INIT_WR;
                cnt      <= '0;
                len      <= '0;
                pix      <= '0;
                grow     <= 1'b0;
                grow_eff <= 1'b0;
            end
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign ate    = (state == S_DONE) && grow;
    assign length = len;

endmodule
